branch_target_table: RTL and testbench

- Parametrised, runtime-writable successor to the fetch-stage jump-target LUT.
- Maps a branch index to a D-bit PC target.
- Each entry is either absolute or PC-relative. Relative entries resolve to (pc + signed offset) mod 2^D.
- Lookup is registered with one cycle of latency. Entries carry valid bits and can be bulk-invalidated by a sequenced flush.

---
 rtl/branch_target_table.sv | 252 +++++++++++++++++++++++++
 tb/tb_branch_target_table.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_table.sv
// branch_target_table
// Runtime-writable branch target table for the fetch stage. Each entry holds
// a D-bit value, a relative flag and a valid bit. Relative entries resolve to
// (pc + offset) mod 2^D. Lookups are registered and take one cycle. A
// sequenced flush invalidates one entry per cycle; while it runs, lookups
// miss and writes are dropped.
//
// Optional build macro: BTT_HIT_COUNT_EN adds saturating hit/miss counters.
// When the macro is not defined, hit_count and miss_count are tied to zero.
module branch_target_table #(
    parameter int D     = 12,
    parameter int DEPTH = 256,
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          lookup_req,
    input  logic [IW-1:0] lookup_idx,
    input  logic [D-1:0]  pc,
    output logic [D-1:0]  target,
    output logic          target_valid,
    output logic          hit,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [D-1:0]  wr_target,
    input  logic          wr_rel,
    input  logic          wr_clr,
    output logic          wr_drop,
    input  logic          flush_req,
    output logic          busy,
    output logic [15:0]   hit_count,
    output logic [15:0]   miss_count
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // FSM and flush sequencing
    state_t        state_r;
    state_t        state_next_s;
    logic [IW-1:0] flush_cnt_r;
    logic          flushing_s;
    logic          enter_flush_s;
    logic          busy_next_s;
    logic          wr_accept_s;

    // Table storage
    logic [D-1:0]     val_r [DEPTH];
    logic [DEPTH-1:0] rel_r;
    logic [DEPTH-1:0] vld_r;

    // Lookup datapath
    logic          bypass_s;
    logic [D-1:0]  sel_val_s;
    logic          sel_rel_s;
    logic          sel_vld_s;
    logic          lk_hit_s;
    logic [D-1:0]  lk_target_s;

    // Registered outputs
    logic [D-1:0]  target_r;
    logic          hit_r;
    logic          target_valid_r;
    logic          wr_drop_r;
    logic          busy_r;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic: flush runs until the last entry has been cleared
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (flush_req) begin
                    state_next_s = ST_FLUSH;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_r == IW'(DEPTH - 1)) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_FLUSH;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM output decode: flush qualifiers and write acceptance
    always_comb begin
        flushing_s    = 1'b0;
        enter_flush_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                flushing_s    = 1'b0;
                enter_flush_s = flush_req;
            end
            ST_FLUSH: begin
                flushing_s    = 1'b1;
                enter_flush_s = 1'b0;
            end
            default: begin
                flushing_s    = 1'b0;
                enter_flush_s = 1'b0;
            end
        endcase
        busy_next_s = (state_next_s == ST_FLUSH);
        wr_accept_s = wr_en & ~flushing_s;
    end

    // Flush index: held at zero while idle so every flush starts at entry 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_cnt_r <= {IW{1'b0}};
        end else if (flushing_s) begin
            flush_cnt_r <= flush_cnt_r + IW'(1);
        end else begin
            flush_cnt_r <= {IW{1'b0}};
        end
    end

    // Table storage: preload on reset, flush clears one entry per cycle,
    // otherwise accepted writes load or invalidate an entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                val_r[IW'(i)] <= {D{1'b0}};
            end
            val_r[IW'(0)] <= D'(15);
            val_r[IW'(1)] <= D'(1);
            val_r[IW'(2)] <= D'(4);
            val_r[IW'(3)] <= D'(137);
            rel_r         <= {DEPTH{1'b0}};
            vld_r         <= {{(DEPTH-4){1'b0}}, 4'b1111};
        end else if (flushing_s) begin
            vld_r[flush_cnt_r] <= 1'b0;
        end else if (wr_en) begin
            if (wr_clr) begin
                vld_r[wr_idx] <= 1'b0;
            end else begin
                val_r[wr_idx] <= wr_target;
                rel_r[wr_idx] <= wr_rel;
                vld_r[wr_idx] <= 1'b1;
            end
        end else begin
            vld_r <= vld_r;
        end
    end

    // Entry select with write-first bypass for a same-cycle write to the
    // looked-up index
    always_comb begin
        bypass_s = wr_accept_s & (wr_idx == lookup_idx);
        if (bypass_s) begin
            sel_val_s = wr_target;
            sel_rel_s = wr_rel;
            sel_vld_s = ~wr_clr;
        end else begin
            sel_val_s = val_r[lookup_idx];
            sel_rel_s = rel_r[lookup_idx];
            sel_vld_s = vld_r[lookup_idx];
        end
    end

    // Target resolution: misses and flush-time lookups return zero
    always_comb begin
        if (flushing_s || !sel_vld_s) begin
            lk_hit_s    = 1'b0;
            lk_target_s = {D{1'b0}};
        end else if (sel_rel_s) begin
            lk_hit_s    = 1'b1;
            lk_target_s = pc + sel_val_s;
        end else begin
            lk_hit_s    = 1'b1;
            lk_target_s = sel_val_s;
        end
    end

    // Output registers: target/hit hold between lookups, strobes pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target_r       <= {D{1'b0}};
            hit_r          <= 1'b0;
            target_valid_r <= 1'b0;
            wr_drop_r      <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            target_valid_r <= lookup_req;
            wr_drop_r      <= wr_en & flushing_s;
            busy_r         <= busy_next_s;
            if (lookup_req) begin
                target_r <= lk_target_s;
                hit_r    <= lk_hit_s;
            end else begin
                target_r <= target_r;
                hit_r    <= hit_r;
            end
        end
    end

    assign target       = target_r;
    assign hit          = hit_r;
    assign target_valid = target_valid_r;
    assign wr_drop      = wr_drop_r;
    assign busy         = busy_r;

`ifdef BTT_HIT_COUNT_EN
    logic [15:0] hit_count_r;
    logic [15:0] miss_count_r;

    // Saturating hit/miss statistics, cleared when a flush starts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count_r  <= 16'h0000;
            miss_count_r <= 16'h0000;
        end else if (enter_flush_s) begin
            hit_count_r  <= 16'h0000;
            miss_count_r <= 16'h0000;
        end else if (target_valid_r) begin
            if (hit_r) begin
                if (hit_count_r != 16'hFFFF) begin
                    hit_count_r <= hit_count_r + 16'h0001;
                end
            end else begin
                if (miss_count_r != 16'hFFFF) begin
                    miss_count_r <= miss_count_r + 16'h0001;
                end
            end
        end
    end

    assign hit_count  = hit_count_r;
    assign miss_count = miss_count_r;
`else
    assign hit_count  = 16'h0000;
    assign miss_count = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_target_table.sv
// Self-checking bench for branch_target_table: directed vector table,
// hand-written flush/reset sequences and randomized traffic compared against
// a behavioural table model.
module tb_branch_target_table;

    localparam int D     = 12;
    localparam int DEPTH = 256;
    localparam int IW    = 8;

    logic          clk;
    logic          reset;
    logic          lookup_req;
    logic [IW-1:0] lookup_idx;
    logic [D-1:0]  pc;
    logic [D-1:0]  target;
    logic          target_valid;
    logic          hit;
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [D-1:0]  wr_target;
    logic          wr_rel;
    logic          wr_clr;
    logic          wr_drop;
    logic          flush_req;
    logic          busy;
    logic [15:0]   hit_count;
    logic [15:0]   miss_count;

    branch_target_table #(.D(D), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .lookup_req   (lookup_req),
        .lookup_idx   (lookup_idx),
        .pc           (pc),
        .target       (target),
        .target_valid (target_valid),
        .hit          (hit),
        .wr_en        (wr_en),
        .wr_idx       (wr_idx),
        .wr_target    (wr_target),
        .wr_rel       (wr_rel),
        .wr_clr       (wr_clr),
        .wr_drop      (wr_drop),
        .flush_req    (flush_req),
        .busy         (busy),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model of the table contents and visible outputs
    logic [D-1:0] m_val [DEPTH];
    bit           m_rel [DEPTH];
    bit           m_vld [DEPTH];
    int           m_left;
    logic [D-1:0] m_target;
    bit           m_hit;
    bit           m_tv;
    bit           m_drop;
    int           m_hc;
    int           m_mc;

    typedef struct {
        logic          lreq;
        logic [IW-1:0] lidx;
        logic [D-1:0]  lpc;
        logic          wen;
        logic [IW-1:0] widx;
        logic [D-1:0]  wdata;
        logic          wrel;
        logic          wclr;
        logic          chk;
        logic          exp_hit;
        logic [D-1:0]  exp_target;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(input logic lreq, input int lidx, input int lpc,
                                input logic wen, input int widx, input int wdata,
                                input logic wrel, input logic wclr, input logic chk,
                                input logic eh, input int et);
        vec_t v;
        v.lreq = lreq; v.lidx = IW'(lidx); v.lpc = D'(lpc);
        v.wen = wen; v.widx = IW'(widx); v.wdata = D'(wdata);
        v.wrel = wrel; v.wclr = wclr; v.chk = chk;
        v.exp_hit = eh; v.exp_target = D'(et);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_val[i] = '0;
            m_rel[i] = 1'b0;
            m_vld[i] = (i < 4);
        end
        m_val[0] = 12'd15;
        m_val[1] = 12'd1;
        m_val[2] = 12'd4;
        m_val[3] = 12'd137;
        m_left = 0; m_target = '0; m_hit = 1'b0; m_tv = 1'b0; m_drop = 1'b0;
        m_hc = 0; m_mc = 0;
    endtask

    task automatic idle_inputs();
        lookup_req = 1'b0; lookup_idx = '0; pc = '0;
        wr_en = 1'b0; wr_idx = '0; wr_target = '0; wr_rel = 1'b0; wr_clr = 1'b0;
        flush_req = 1'b0;
    endtask

    task automatic check_outputs();
        check("target_valid", {31'd0, target_valid}, {31'd0, m_tv});
        check("hit", {31'd0, hit}, {31'd0, m_hit});
        check("target", {20'd0, target}, {20'd0, m_target});
        check("busy", {31'd0, busy}, (m_left > 0) ? 32'd1 : 32'd0);
        check("wr_drop", {31'd0, wr_drop}, {31'd0, m_drop});
`ifdef BTT_HIT_COUNT_EN
        check("hit_count", {16'd0, hit_count}, m_hc);
        check("miss_count", {16'd0, miss_count}, m_mc);
`else
        check("hit_count", {16'd0, hit_count}, 32'd0);
        check("miss_count", {16'd0, miss_count}, 32'd0);
`endif
    endtask

    // One clock: drive inputs, predict, advance, compare
    task automatic cycle(input logic lreq, input logic [IW-1:0] lidx, input logic [D-1:0] lpc,
                         input logic wen, input logic [IW-1:0] widx, input logic [D-1:0] wdata,
                         input logic wrel, input logic wclr, input logic freq);
        bit           flushing;
        bit           v;
        bit           r;
        logic [D-1:0] d;
        lookup_req = lreq; lookup_idx = lidx; pc = lpc;
        wr_en = wen; wr_idx = widx; wr_target = wdata; wr_rel = wrel; wr_clr = wclr;
        flush_req = freq;
        flushing = (m_left > 0);
        if (!flushing && freq) begin
            m_hc = 0; m_mc = 0;
        end else if (m_tv) begin
            if (m_hit) m_hc = (m_hc < 65535) ? m_hc + 1 : m_hc;
            else       m_mc = (m_mc < 65535) ? m_mc + 1 : m_mc;
        end
        if (lreq) begin
            if (flushing) begin
                m_hit = 1'b0; m_target = '0;
            end else begin
                if (wen && widx == lidx) begin
                    v = !wclr; r = wrel; d = wdata;
                end else begin
                    v = m_vld[lidx]; r = m_rel[lidx]; d = m_val[lidx];
                end
                m_hit = v;
                m_target = !v ? '0 : (r ? D'(lpc + d) : d);
            end
        end
        m_tv = lreq;
        m_drop = wen && flushing;
        if (flushing) begin
            m_left--;
        end else begin
            if (wen) begin
                if (wclr) m_vld[widx] = 1'b0;
                else begin
                    m_val[widx] = wdata; m_rel[widx] = wrel; m_vld[widx] = 1'b1;
                end
            end
            if (freq) begin
                m_left = DEPTH;
                for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle_cycle();
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic lookup(input int idx, input int lpc);
        cycle(1'b1, IW'(idx), D'(lpc), 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        model_reset();
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset target_valid", {31'd0, target_valid}, 32'd0);
        check("reset hit", {31'd0, hit}, 32'd0);
        check("reset target", {20'd0, target}, 32'd0);
        check("reset wr_drop", {31'd0, wr_drop}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int n;
        idle_inputs();
        reset = 1'b1;
        #2;
        do_reset();

        // Directed vector table
        vecs[0]  = mk(1, 0, 0,      0, 0, 0,      0, 0, 1, 1, 15);
        vecs[1]  = mk(1, 1, 0,      0, 0, 0,      0, 0, 1, 1, 1);
        vecs[2]  = mk(1, 2, 0,      0, 0, 0,      0, 0, 1, 1, 4);
        vecs[3]  = mk(1, 3, 0,      0, 0, 0,      0, 0, 1, 1, 137);
        vecs[4]  = mk(1, 4, 0,      0, 0, 0,      0, 0, 1, 0, 0);
        vecs[5]  = mk(0, 0, 0,      1, 9, 'hFFB,  1, 0, 0, 0, 0);
        vecs[6]  = mk(1, 9, 4,      0, 0, 0,      0, 0, 1, 1, 'hFFF);
        vecs[7]  = mk(0, 0, 0,      1, 9, 'h014,  1, 0, 0, 0, 0);
        vecs[8]  = mk(1, 9, 'h003,  0, 0, 0,      0, 0, 1, 1, 'h017);
        vecs[9]  = mk(0, 0, 0,      1, 10, 'h002, 1, 0, 0, 0, 0);
        vecs[10] = mk(1, 10, 'hFFF, 0, 0, 0,      0, 0, 1, 1, 'h001);
        vecs[11] = mk(1, 5, 0,      1, 5, 42,     0, 0, 1, 1, 42);
        vecs[12] = mk(1, 0, 0,      1, 0, 0,      0, 1, 1, 0, 0);
        vecs[13] = mk(1, 0, 0,      0, 0, 0,      0, 0, 1, 0, 0);
        for (int i = 0; i < 14; i++) begin
            cycle(vecs[i].lreq, vecs[i].lidx, vecs[i].lpc, vecs[i].wen, vecs[i].widx,
                  vecs[i].wdata, vecs[i].wrel, vecs[i].wclr, 1'b0);
            if (vecs[i].chk) begin
                check($sformatf("vec%0d hit", i), {31'd0, hit}, {31'd0, vecs[i].exp_hit});
                check($sformatf("vec%0d target", i), {20'd0, target}, {20'd0, vecs[i].exp_target});
            end
        end

        // Full flush with a dropped write and a lookup inside it
        do_reset();
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            n++;
            if (n == 10) begin
                cycle(1'b0, '0, '0, 1'b1, IW'(7), D'(99), 1'b0, 1'b0, 1'b0);
                check("flush wr_drop", {31'd0, wr_drop}, 32'd1);
            end else if (n == 20) begin
                lookup(1, 0);
                check("flush lookup valid", {31'd0, target_valid}, 32'd1);
                check("flush lookup hit", {31'd0, hit}, 32'd0);
            end else begin
                idle_cycle();
            end
        end
        check("busy length", n, DEPTH);
        for (int i = 0; i < 4; i++) begin
            lookup(i, 0);
            check($sformatf("post-flush idx%0d hit", i), {31'd0, hit}, 32'd0);
        end
        lookup(7, 0);
        check("dropped write idx7 hit", {31'd0, hit}, 32'd0);

        // Reset in the middle of a flush
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        repeat (100) idle_cycle();
        reset = 1'b1;
        #1;
        check("midflush reset busy", {31'd0, busy}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        lookup(3, 0);
        check("post-reset idx3 hit", {31'd0, hit}, 32'd1);
        check("post-reset idx3 target", {20'd0, target}, 32'd137);

        // Hit/miss statistics and their clearing at flush start
        do_reset();
        lookup(0, 0);
        lookup(1, 0);
        lookup(2, 0);
        lookup(4, 0);
        lookup(5, 0);
        idle_cycle();
        idle_cycle();
`ifdef BTT_HIT_COUNT_EN
        check("stat hit_count", {16'd0, hit_count}, 32'd3);
        check("stat miss_count", {16'd0, miss_count}, 32'd2);
`else
        check("stat hit_count", {16'd0, hit_count}, 32'd0);
        check("stat miss_count", {16'd0, miss_count}, 32'd0);
`endif
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        check("flush clears hit_count", {16'd0, hit_count}, 32'd0);
        check("flush clears miss_count", {16'd0, miss_count}, 32'd0);
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            n++;
            idle_cycle();
        end
        check("second flush length", n, DEPTH);

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 600; k++) begin
            cycle(1'($urandom_range(0, 1)), IW'($urandom_range(0, 15)), D'($urandom),
                  1'($urandom_range(0, 1)), IW'($urandom_range(0, 15)), D'($urandom),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 299) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
